// File: rtl/irrigation_countdown_scan.sv
// irrigation_countdown_scan: single-clock MM..M:SS BCD irrigation countdown with
// per-mode presets, water-sensor pause, start/cancel control, done pulse and a
// multiplexed 7-segment scan driver for all ND = MIN_DIGITS+2 digits.
// Optional build macro BLINK_EN: blank the display at 1 Hz while paused or done.
module irrigation_countdown_scan #(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned SCAN_HZ        = 400,
  parameter int unsigned MIN_DIGITS     = 2,
  parameter int unsigned PRESET_DRIP_S  = 1200,
  parameter int unsigned PRESET_SPRAY_S = 900,
  parameter int unsigned PRESET_SPEC_S  = 580,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      mode_drip,
  input  logic                      mode_spray,
  input  logic                      mode_spec,
  input  logic                      start,
  input  logic                      cancel,
  input  logic                      sensor_ok,
  output logic [6:0]                seg,
  output logic [MIN_DIGITS+1:0]     dig_en,
  output logic [4*MIN_DIGITS+7:0]   bcd,
  output logic                      running,
  output logic                      paused,
  output logic                      done
);

  localparam int unsigned ND           = MIN_DIGITS + 2;
  localparam int unsigned BW           = 4 * ND;
  localparam int unsigned TICK_W       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned SCAN_DIV_RAW = CLK_HZ / SCAN_HZ;
  localparam int unsigned SCAN_DIV     = (SCAN_DIV_RAW > 0) ? SCAN_DIV_RAW : 1;
  localparam int unsigned SCAN_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W        = $clog2(ND);
  localparam logic        POL          = (SEG_ACTIVE_LOW != 0);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(ND - 1);

  // Seconds -> MM..M:SS BCD, saturating at all-9 minutes and 59 seconds.
  function automatic logic [BW-1:0] to_bcd(input int unsigned secs);
    int unsigned max_s;
    int unsigned mins;
    int unsigned s;
    logic [BW-1:0] r;
    max_s = 1;
    for (int unsigned i = 0; i < MIN_DIGITS; i++) max_s = max_s * 10;
    max_s = max_s * 60 - 1;
    if (secs > max_s) begin
      mins = max_s / 60;
      s    = 59;
    end else begin
      mins = secs / 60;
      s    = secs % 60;
    end
    r = '0;
    r[3:0] = 4'(s % 10);
    r[7:4] = 4'(s / 10);
    for (int unsigned i = 0; i < MIN_DIGITS; i++) begin
      r[4*(i+2) +: 4] = 4'(mins % 10);
      mins = mins / 10;
    end
    return r;
  endfunction

  // Standard 0-9 decode in {g,f,e,d,c,b,a}, active high; other codes blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  localparam logic [BW-1:0] PRESET_DRIP  = to_bcd(PRESET_DRIP_S);
  localparam logic [BW-1:0] PRESET_SPRAY = to_bcd(PRESET_SPRAY_S);
  localparam logic [BW-1:0] PRESET_SPEC  = to_bcd(PRESET_SPEC_S);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t             state, state_next;
  logic [BW-1:0]      count, count_next, count_dec, preset_sel;
  logic [TICK_W-1:0]  tick_cnt, tick_next;
  logic               start_q, start_rise, mode_valid, tick, done_next;
  logic               blank;
  logic [SCAN_W-1:0]  scan_cnt;
  logic               scan_en;
  logic [IDX_W-1:0]   scan_idx;
  logic [3:0]         cur_digit;
  logic [ND-1:0]      onehot;

  assign start_rise = start & ~start_q;
  assign tick       = (state == RUN) && (tick_cnt == TICK_LAST);
  assign scan_en    = (scan_cnt == SCAN_LAST);
  assign bcd        = count;
  assign running    = (state == RUN);
  assign paused     = (state == PAUSE);

  // Mode priority: specific > drip > sprinkler.
  always_comb begin
    preset_sel = '0;
    mode_valid = 1'b1;
    if (mode_spec)       preset_sel = PRESET_SPEC;
    else if (mode_drip)  preset_sel = PRESET_DRIP;
    else if (mode_spray) preset_sel = PRESET_SPRAY;
    else                 mode_valid = 1'b0;
  end

  // BCD borrow-chain decrement of the live count.
  always_comb begin
    logic borrow;
    count_dec = count;
    borrow    = 1'b1;
    for (int unsigned i = 0; i < ND; i++) begin
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
        end else begin
          count_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // Next state, next count, prescaler and done pulse; cancel overrides all.
  always_comb begin
    state_next = state;
    count_next = count;
    tick_next  = tick_cnt;
    done_next  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_rise && mode_valid) begin
          count_next = preset_sel;
          tick_next  = '0;
          if (preset_sel == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next = sensor_ok ? RUN : PAUSE;
          end
        end
      end
      RUN: begin
        if (tick) begin
          tick_next  = '0;
          count_next = count_dec;
          if (count_dec == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else if (!sensor_ok) begin
            state_next = PAUSE;
          end
        end else begin
          tick_next = tick_cnt + TICK_W'(1);
          if (!sensor_ok) state_next = PAUSE;
        end
      end
      PAUSE: begin
        if (sensor_ok) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
    if (cancel) begin
      state_next = IDLE;
      count_next = '0;
      tick_next  = '0;
      done_next  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Count, tick prescaler, done pulse and start edge history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      tick_cnt <= '0;
      done     <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      count    <= count_next;
      tick_cnt <= tick_next;
      done     <= done_next;
      start_q  <= start;
    end
  end

`ifdef BLINK_EN
  logic [TICK_W-1:0] blink_cnt;

  // Free-running one-second phase, independent of pause, for the blink.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    blink_cnt <= '0;
    else if (blink_cnt == TICK_LAST) blink_cnt <= '0;
    else                             blink_cnt <= blink_cnt + TICK_W'(1);
  end

  assign blank = ((state == PAUSE) || (state == DONE)) &&
                 (blink_cnt >= TICK_W'(CLK_HZ / 2));
`else
  assign blank = 1'b0;
`endif

  // Scan prescaler and digit index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_en) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Digit selected by the scan index.
  always_comb begin
    cur_digit = 4'd0;
    onehot    = '0;
    for (int unsigned i = 0; i < ND; i++) begin
      if (scan_idx == IDX_W'(i)) begin
        cur_digit = count[4*i +: 4];
        onehot[i] = 1'b1;
      end
    end
  end

  // Registered display drive with polarity applied.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg    <= {7{POL}};
      dig_en <= {ND{POL}};
    end else begin
      seg    <= (blank ? 7'h00 : seg_decode(cur_digit)) ^ {7{POL}};
      dig_en <= onehot ^ {ND{POL}};
    end
  end

endmodule

// File: tb/tb_irrigation_countdown_scan.sv
// Self-checking bench for irrigation_countdown_scan: directed scenarios plus a
// randomized run against a seconds-based behavioural model of the countdown.
module tb_irrigation_countdown_scan;

  localparam int CLK_HZ  = 20;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mode_drip = 1'b0, mode_spray = 1'b0, mode_spec = 1'b0;
  logic start = 1'b0, cancel = 1'b0, sensor_ok = 1'b1;

  logic [6:0]  seg1, seg2;
  logic [3:0]  dig_en1;
  logic [4:0]  dig_en2;
  logic [15:0] bcd1;
  logic [19:0] bcd2;
  logic running1, paused1, done1, running2, paused2, done2;

  int checks = 0;
  int errors = 0;

  // Model state (unit 1 only): seconds remaining, cycles since last tick.
  int   m_st, m_secs, m_phase;
  logic m_done, m_prev;

  always #5 clk = ~clk;

  irrigation_countdown_scan #(
    .CLK_HZ(20), .SCAN_HZ(5), .MIN_DIGITS(2), .PRESET_DRIP_S(1200),
    .PRESET_SPRAY_S(754), .PRESET_SPEC_S(5), .SEG_ACTIVE_LOW(1)
  ) u1 (
    .clk(clk), .reset_n(reset_n), .mode_drip(mode_drip), .mode_spray(mode_spray),
    .mode_spec(mode_spec), .start(start), .cancel(cancel), .sensor_ok(sensor_ok),
    .seg(seg1), .dig_en(dig_en1), .bcd(bcd1), .running(running1),
    .paused(paused1), .done(done1)
  );

  irrigation_countdown_scan #(
    .CLK_HZ(20), .SCAN_HZ(5), .MIN_DIGITS(3), .PRESET_DRIP_S(6000),
    .PRESET_SPRAY_S(70000), .PRESET_SPEC_S(0), .SEG_ACTIVE_LOW(1)
  ) u2 (
    .clk(clk), .reset_n(reset_n), .mode_drip(mode_drip), .mode_spray(mode_spray),
    .mode_spec(mode_spec), .start(start), .cancel(cancel), .sensor_ok(sensor_ok),
    .seg(seg2), .dig_en(dig_en2), .bcd(bcd2), .running(running2),
    .paused(paused2), .done(done2)
  );

  function automatic logic [15:0] exp_bcd(input int s);
    int m;
    m = s / 60;
    return {4'((m / 10) % 10), 4'(m % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0111111;  1: return 7'b0000110;  2: return 7'b1011011;
      3: return 7'b1001111;  4: return 7'b1100110;  5: return 7'b1101101;
      6: return 7'b1111101;  7: return 7'b0000111;  8: return 7'b1111111;
      9: return 7'b1101111;  default: return 7'b0000000;
    endcase
  endfunction

  function automatic int preset_secs();
    if (mode_spec)  return 5;
    if (mode_drip)  return 1200;
    if (mode_spray) return 754;
    return -1;
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_secs = 0; m_phase = 0; m_done = 1'b0; m_prev = 1'b0;
  endtask

  task automatic model_step();
    logic rise;
    int p;
    rise   = start && !m_prev;
    m_prev = start;
    m_done = 1'b0;
    p      = preset_secs();
    if (cancel) begin
      m_st = S_IDLE; m_secs = 0; m_phase = 0;
    end else if (m_st == S_IDLE || m_st == S_DONE) begin
      if (rise && p >= 0) begin
        m_secs = p; m_phase = 0;
        if (p == 0) begin m_st = S_DONE; m_done = 1'b1; end
        else m_st = sensor_ok ? S_RUN : S_PAUSE;
      end
    end else if (m_st == S_RUN) begin
      m_phase++;
      if (m_phase == CLK_HZ) begin
        m_phase = 0;
        m_secs--;
        if (m_secs == 0) begin m_st = S_DONE; m_done = 1'b1; end
        else if (!sensor_ok) m_st = S_PAUSE;
      end else if (!sensor_ok) begin
        m_st = S_PAUSE;
      end
    end else if (m_st == S_PAUSE) begin
      if (sensor_ok) m_st = S_RUN;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bcd1 !== 16'h0000) begin errors++; $display("FAIL reset_bcd1 got=%h exp=0000", bcd1); end
    checks++; if (bcd2 !== 20'h00000) begin errors++; $display("FAIL reset_bcd2 got=%h exp=00000", bcd2); end
    checks++; if ({running1, paused1, done1} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {running1, paused1, done1}); end
    checks++; if (seg1 !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=7f", seg1); end
    checks++; if (dig_en1 !== 4'hF) begin errors++; $display("FAIL reset_dig_en1 got=%h exp=f", dig_en1); end
    checks++; if (dig_en2 !== 5'h1F) begin errors++; $display("FAIL reset_dig_en2 got=%h exp=1f", dig_en2); end
    reset_n = 1'b1;
    model_reset();
    cycle();
    checks++; if ({running1, paused1, bcd1} !== 18'h0) begin errors++; $display("FAIL post_reset_idle got=%b/%b/%h exp=idle", running1, paused1, bcd1); end
  endtask

  task automatic test_spec_countdown();
    int n, done_cnt;
    logic [15:0] prev;
    done_cnt = 0;
    mode_spec = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    checks++; if (bcd1 !== 16'h0005) begin errors++; $display("FAIL spec_load got=%h exp=0005", bcd1); end
    checks++; if (running1 !== 1'b1) begin errors++; $display("FAIL spec_running got=%b exp=1", running1); end
    checks++; if ({done2, running2, bcd2} !== {2'b10, 20'h0}) begin errors++; $display("FAIL zero_load got done=%b run=%b bcd=%h exp done=1 run=0 bcd=0", done2, running2, bcd2); end
    cycle();
    checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL zero_load_pulse got=%b exp=0", done2); end
    for (int v = 4; v >= 0; v--) begin
      n = 0;
      prev = bcd1;
      for (int i = 0; i < 40 && bcd1 === prev; i++) begin
        cycle();
        n++;
        if (done1 === 1'b1) done_cnt++;
      end
      if (v == 4) n++;
      checks++; if (bcd1 !== exp_bcd(v)) begin errors++; $display("FAIL spec_value got=%h exp=%h", bcd1, exp_bcd(v)); end
      checks++; if (n !== CLK_HZ) begin errors++; $display("FAIL spec_spacing got=%0d exp=%0d", n, CLK_HZ); end
      checks++; if (done1 !== (v == 0)) begin errors++; $display("FAIL spec_done_at_%0d got=%b exp=%b", v, done1, v == 0); end
    end
    repeat (3) cycle();
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL done_pulse_count got=%0d exp=1", done_cnt); end
    checks++; if ({running1, paused1, done1, bcd1} !== 19'h0) begin errors++; $display("FAIL done_hold got run=%b pause=%b done=%b bcd=%h exp 0/0/0/0000", running1, paused1, done1, bcd1); end
  endtask

  task automatic test_drip_borrow();
    cancel = 1'b1; start = 1'b0;
    cycle();
    cancel = 1'b0; mode_spec = 1'b0; mode_drip = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    checks++; if (bcd1 !== 16'h2000) begin errors++; $display("FAIL drip_load got=%h exp=2000", bcd1); end
    checks++; if (bcd2 !== 20'h10000) begin errors++; $display("FAIL drip3_load got=%h exp=10000", bcd2); end
    mode_spec = 1'b1;
    repeat (CLK_HZ) cycle();
    checks++; if (bcd1 !== 16'h1959) begin errors++; $display("FAIL drip_borrow got=%h exp=1959", bcd1); end
    checks++; if (bcd2 !== 20'h09959) begin errors++; $display("FAIL drip3_borrow got=%h exp=09959", bcd2); end
    checks++; if (running1 !== 1'b1) begin errors++; $display("FAIL drip_running got=%b exp=1", running1); end
  endtask

  task automatic test_pause();
    int n;
    cancel = 1'b1;
    cycle();
    cancel = 1'b0; mode_drip = 1'b0; mode_spec = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 60 && bcd1 !== 16'h0003; i++) cycle();
    checks++; if (bcd1 !== 16'h0003) begin errors++; $display("FAIL pause_reach got=%h exp=0003", bcd1); end
    repeat (5) cycle();
    sensor_ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      checks++; if ({paused1, bcd1} !== {1'b1, 16'h0003}) begin errors++; $display("FAIL pause_hold got p=%b bcd=%h exp p=1 bcd=0003", paused1, bcd1); end
    end
    sensor_ok = 1'b1;
    n = 0;
    for (int i = 0; i < 40 && bcd1 === 16'h0003; i++) begin cycle(); n++; end
    checks++; if (bcd1 !== 16'h0002) begin errors++; $display("FAIL pause_resume got=%h exp=0002", bcd1); end
    checks++; if (n !== 15) begin errors++; $display("FAIL pause_remaining got=%0d exp=15", n); end
  endtask

  task automatic test_cancel();
    cancel = 1'b1;
    cycle();
    cancel = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (CLK_HZ - 1) cycle();
    cancel = 1'b1; start = 1'b1;
    cycle();
    cancel = 1'b0;
    checks++; if ({running1, paused1, done1, bcd1} !== 19'h0) begin errors++; $display("FAIL cancel_prio got run=%b p=%b done=%b bcd=%h exp idle 0000", running1, paused1, done1, bcd1); end
    cycle();
    checks++; if ({running1, bcd1} !== 17'h0) begin errors++; $display("FAIL held_start got run=%b bcd=%h exp idle", running1, bcd1); end
    start = 1'b0; mode_spec = 1'b0;
    cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++; if ({running1, paused1, done1, bcd1} !== 19'h0) begin errors++; $display("FAIL no_mode got run=%b p=%b done=%b bcd=%h exp idle", running1, paused1, done1, bcd1); end
  endtask

  task automatic test_async_reset();
    mode_drip = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (7) cycle();
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({running1, bcd1} !== 17'h0) begin errors++; $display("FAIL async_reset got run=%b bcd=%h exp 0", running1, bcd1); end
    checks++; if ({seg1, dig_en1} !== 11'h7FF) begin errors++; $display("FAIL async_reset_disp got seg=%h dig=%h exp 7f/f", seg1, dig_en1); end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++; if ({running1, bcd1} !== {1'b1, 16'h2000}) begin errors++; $display("FAIL reset_reload got run=%b bcd=%h exp 1/2000", running1, bcd1); end
  endtask

  task automatic test_scan();
    logic [3:0] prev;
    logic found;
    int d;
    cancel = 1'b1;
    cycle();
    cancel = 1'b0; mode_drip = 1'b0; mode_spray = 1'b1; sensor_ok = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    checks++; if ({paused1, bcd1} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL spray_load got p=%b bcd=%h exp 1/1234", paused1, bcd1); end
    checks++; if ({paused2, bcd2} !== {1'b1, 20'h99959}) begin errors++; $display("FAIL saturate got p=%b bcd=%h exp 1/99959", paused2, bcd2); end
`ifndef BLINK_EN
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      prev = dig_en1;
      cycle();
      if (dig_en1 === 4'b1110 && prev !== 4'b1110) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL scan_sync got=%b exp=1", found); end
    for (int k = 0; k < 16; k++) begin
      d = k / 4;
      checks++; if (dig_en1 !== ~(4'b0001 << d)) begin errors++; $display("FAIL scan_dig k=%0d got=%b exp=%b", k, dig_en1, ~(4'b0001 << d)); end
      checks++; if (seg1 !== ~seg_of(4 - d)) begin errors++; $display("FAIL scan_seg k=%0d got=%h exp=%h", k, seg1, ~seg_of(4 - d)); end
      cycle();
    end
`else
    d = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (seg1 === 7'h7F) d++;
    end
    checks++; if (d !== 20) begin errors++; $display("FAIL blink_blank got=%0d exp=20", d); end
`endif
    sensor_ok = 1'b1;
  endtask

  task automatic test_random();
    cancel = 1'b1;
    cycle();
    cancel = 1'b0; mode_spray = 1'b0; mode_spec = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 8 == 0) start = ~start;
      cancel    = ($urandom % 97 == 0);
      sensor_ok = ($urandom % 12 != 0);
      if ($urandom % 200 == 0) begin
        mode_spec  = 1'($urandom % 2);
        mode_drip  = 1'($urandom % 2);
        mode_spray = 1'($urandom % 2);
      end
      cycle();
      checks++; if (bcd1 !== exp_bcd(m_secs)) begin errors++; $display("FAIL rand_bcd cyc=%0d got=%h exp=%h", i, bcd1, exp_bcd(m_secs)); end
      checks++; if ({running1, paused1} !== {m_st == S_RUN, m_st == S_PAUSE}) begin errors++; $display("FAIL rand_state cyc=%0d got=%b%b exp=%b%b", i, running1, paused1, m_st == S_RUN, m_st == S_PAUSE); end
      checks++; if (done1 !== m_done) begin errors++; $display("FAIL rand_done cyc=%0d got=%b exp=%b", i, done1, m_done); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_spec_countdown();
    test_drip_borrow();
    test_pause();
    test_cancel();
    test_async_reset();
    test_scan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irrigation_countdown_scan.md
Name: irrigation_countdown_scan

Overview:
- Parametrised successor to the four-digit irrigation countdown: a single-clock MM..M:SS BCD countdown timer with per-mode presets (drip, sprinkler, specific).
- Holds water-sensor pause, start/cancel control and a done pulse.
- Contains an integrated multiplexed 7-segment scan driver for all digits.
- Sits between the mode/sensor front end and the board display; internal clock-enable prescalers replace the ripple clocks.

Parameters:
- CLK_HZ, 50000000, system clock frequency; the 1 s tick is generated every CLK_HZ cycles.
- SCAN_HZ, 400, digit scan rate; scan enable every CLK_HZ/SCAN_HZ cycles (integer division, minimum 1).
- MIN_DIGITS, 2, number of BCD minute digits (1..4); total digits ND = MIN_DIGITS+2.
- PRESET_DRIP_S, 1200, drip preset in seconds (20:00).
- PRESET_SPRAY_S, 900, sprinkler preset in seconds (15:00).
- PRESET_SPEC_S, 580, specific preset in seconds (09:40).
- SEG_ACTIVE_LOW, 1, 1 = segments and digit enables active low.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mode_drip  in  1  drip mode select, level.
- mode_spray  in  1  sprinkler mode select, level.
- mode_spec  in  1  specific mode select, level.
- start  in  1  start request, synchronous level; the rising edge is detected internally.
- cancel  in  1  abort, level, synchronous.
- sensor_ok  in  1  water available; 0 freezes the countdown.
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dig_en  out  ND  one-hot digit enable; bit 0 = seconds units.
- bcd  out  4*ND  live count, digit 0 in the LSBs.
- running  out  1  state RUN.
- paused  out  1  state PAUSE.
- done  out  1  one-cycle pulse on reaching zero.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE, bcd all 0, running/paused/done 0.
  - Prescalers 0, scan index 0; seg and dig_en at their inactive level.
- Mode priority: mode_spec > mode_drip > mode_spray.
  - No mode asserted: start is ignored.
- Preset conversion happens at elaboration only: seconds -> MM:SS BCD.
  - A preset exceeding 10^MIN_DIGITS*60-1 saturates to all-9 minutes and 59 seconds.
- States:
  - IDLE: a start rising edge with a valid mode loads the preset and moves to RUN, or to PAUSE if sensor_ok=0.
  - RUN: each tick decrements the count; sensor_ok=0 moves to PAUSE on the next clk.
  - PAUSE: count frozen, tick prescaler held; sensor_ok=1 returns to RUN.
  - DONE: count 00:00, hold; a start rising edge reloads the preset as in IDLE.
  - cancel in any state: IDLE, bcd cleared to 0, same cycle as the next clk edge; cancel has priority over start and tick.
- Tick prescaler:
  - Counts only in RUN and reloads to 0 on entry to RUN from IDLE/DONE.
  - First tick comes CLK_HZ cycles after load.
- Decrement (BCD borrow chain):
  - Seconds units 0 -> 9 with borrow; seconds tens 0 -> 5 with borrow.
  - Each minute digit 0 -> 9 with borrow.
  - The decrement that produces all-zero moves to DONE and pulses done in that same cycle; running drops the next cycle.
- Zero load (preset 0 s): go straight to DONE with a done pulse, no RUN cycles.
- Start held high: no retrigger; a new rising edge is required.
- A mode change during RUN/PAUSE is ignored until the next load.
- Scan:
  - Each scan enable advances the index 0..ND-1 and wraps to 0.
  - dig_en and seg are registered, one clk latency from the index change.
  - Decode 0-9 standard; codes 10-15 blank.
- Simultaneous tick and sensor_ok fall: the tick is applied, then PAUSE.

Optional Feature:
- BLINK_EN defined: in PAUSE and DONE all digits blank at 1 Hz, 50% duty (500 ms on/off), derived from the free-running second prescaler; bcd output is unaffected.
- BLINK_EN undefined: digits are always lit.

Test Plan:
- CLK_HZ=20, SCAN_HZ=5, PRESET_SPEC_S=5; mode_spec+start -> bcd 00:05, then 00:04..00:00 at 20-cycle spacing; done is a single pulse in the cycle the count reaches 00:00; state DONE.
- Drip preset 1200: load 20:00 -> after 1 tick 19:59, borrow across all digits; MIN_DIGITS=3 with a 6000 s preset -> 100:00 -> 099:59.
- sensor_ok=0 mid-run at 00:03 for 50 cycles -> paused=1, count stays 00:03; release -> resumes, reaches 00:02 only after the remaining prescaler cycles.
- cancel asserted together with start and a tick -> IDLE, bcd 0, done 0; start with no mode -> stays IDLE.
- reset_n low asynchronously between clk edges during RUN -> outputs reset immediately; after release, start reload works.
- Scan: bcd 12:34 -> dig_en cycles bit0..bit3 every 4 cycles with seg patterns for 4,3,2,1 (active low); with BLINK_EN in PAUSE, seg blank for 10 of every 20 cycles.
